// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared constants, state type and alignment helper for the DMEM arbiter
package dmem_arb_pkg;

   // Access size codes; any other code is rejected as misaligned
   localparam logic [2:0] SIZE_BYTE = 3'b001;
   localparam logic [2:0] SIZE_HALF = 3'b010;
   localparam logic [2:0] SIZE_WORD = 3'b100;

   // Requester ids used for the owner and last-grant registers
   localparam logic OWNER_M0 = 1'b0;
   localparam logic OWNER_M1 = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // True when the access must not reach DMEM (bad size code or unaligned address)
   function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = addr_lo[0];
         SIZE_WORD: bad = (addr_lo != 2'b00);
         default:   bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rtl/dmem_arbiter_rr_pick2.sv - two-way winner selection with exclusion, round-robin or fixed priority
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic       req0,
   input  logic       req1,
   input  logic       last,
   input  logic [1:0] exclude,
   input  logic       fixed,
   output logic       winner,
   output logic       valid
);

   logic elig0;
   logic elig1;

   assign elig0 = req0 & ~exclude[0];
   assign elig1 = req1 & ~exclude[1];

   // On a tie, fixed mode favours M0; otherwise favour whoever was not granted last
   always_comb begin
      valid  = elig0 | elig1;
      winner = OWNER_M0;
      if (elig0 && elig1) begin
         winner = fixed ? OWNER_M0 : ~last;
      end else if (elig1) begin
         winner = OWNER_M1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master DMEM arbiter with IDLE/ACC/RESP sequencing
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int FIXED_PRIO = 0
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        m0_req,
   input  logic        m0_we,
   input  logic        m0_sign,
   input  logic [2:0]  m0_size,
   input  logic [11:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_done,
   output logic        m0_err,
   output logic [31:0] m0_rdata,

   input  logic        m1_req,
   input  logic        m1_we,
   input  logic        m1_sign,
   input  logic [2:0]  m1_size,
   input  logic [11:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_done,
   output logic        m1_err,
   output logic [31:0] m1_rdata,

   output logic        DM_W,
   output logic        DM_R,
   output logic        DM_sign,
   output logic [2:0]  DM_size,
   output logic [11:0] DM_addr,
   output logic [31:0] DM_wdata,
   input  logic [31:0] DM_rdata
);

   state_t      state;
   state_t      state_next;
   logic        owner;
   logic        last_gnt;
   logic        take;

   logic        cmd_we;
   logic        cmd_sign;
   logic [2:0]  cmd_size;
   logic [11:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        cmd_bad;

   logic [1:0]  exclude;
   logic        pick_winner;
   logic        pick_valid;

   logic        sel_we;
   logic        sel_sign;
   logic [2:0]  sel_size;
   logic [11:0] sel_addr;
   logic [31:0] sel_wdata;

   // The current owner may not win again straight out of its own response cycle
   assign exclude = (state == ST_RESP) ? ((owner == OWNER_M1) ? 2'b10 : 2'b01) : 2'b00;

   rr_pick2 u_pick (
      .req0    (m0_req),
      .req1    (m1_req),
      .last    (last_gnt),
      .exclude (exclude),
      .fixed   (FIXED_PRIO != 0),
      .winner  (pick_winner),
      .valid   (pick_valid)
   );

   assign sel_we    = pick_winner ? m1_we    : m0_we;
   assign sel_sign  = pick_winner ? m1_sign  : m0_sign;
   assign sel_size  = pick_winner ? m1_size  : m0_size;
   assign sel_addr  = pick_winner ? m1_addr  : m0_addr;
   assign sel_wdata = pick_winner ? m1_wdata : m0_wdata;

   // Next-state and grant decode; a grant can be issued from IDLE or RESP
   always_comb begin
      state_next = state;
      take       = 1'b0;
      m0_gnt     = 1'b0;
      m1_gnt     = 1'b0;
      case (state)
         ST_IDLE, ST_RESP: begin
            if (pick_valid) begin
               take       = 1'b1;
               state_next = ST_ACC;
               m0_gnt     = (pick_winner == OWNER_M0);
               m1_gnt     = (pick_winner == OWNER_M1);
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_ACC:  state_next = ST_RESP;
         default: state_next = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Latch the winning command, owner and last-grant on every grant
   always_ff @(posedge clk) begin
      if (rst) begin
         owner     <= OWNER_M0;
         last_gnt  <= OWNER_M1;
         cmd_we    <= 1'b0;
         cmd_sign  <= 1'b0;
         cmd_size  <= 3'b000;
         cmd_addr  <= 12'h000;
         cmd_wdata <= 32'h0000_0000;
         cmd_bad   <= 1'b0;
      end else if (take) begin
         owner     <= pick_winner;
         last_gnt  <= pick_winner;
         cmd_we    <= sel_we;
         cmd_sign  <= sel_sign;
         cmd_size  <= sel_size;
         cmd_addr  <= sel_addr;
         cmd_wdata <= sel_wdata;
         cmd_bad   <= is_misaligned(sel_size, sel_addr[1:0]);
      end
   end

   // Capture read data into the owner's holding register at the end of a good read
   always_ff @(posedge clk) begin
      if (rst) begin
         m0_rdata <= 32'h0000_0000;
         m1_rdata <= 32'h0000_0000;
      end else if (state == ST_ACC && !cmd_we && !cmd_bad) begin
         if (owner == OWNER_M1) begin
            m1_rdata <= DM_rdata;
         end else begin
            m0_rdata <= DM_rdata;
         end
      end
   end

   assign DM_W     = (state == ST_ACC) &  cmd_we & ~cmd_bad;
   assign DM_R     = (state == ST_ACC) & ~cmd_we & ~cmd_bad;
   assign DM_sign  = cmd_sign;
   assign DM_size  = cmd_size;
   assign DM_addr  = cmd_addr;
   assign DM_wdata = cmd_wdata;

   assign m0_done = (state == ST_RESP) & (owner == OWNER_M0);
   assign m1_done = (state == ST_RESP) & (owner == OWNER_M1);
   assign m0_err  = m0_done & cmd_bad;
   assign m1_err  = m1_done & cmd_bad;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

   logic        clk;
   logic        rst;
   logic        m0_req, m0_we, m0_sign;
   logic [2:0]  m0_size;
   logic [11:0] m0_addr;
   logic [31:0] m0_wdata;
   logic        m1_req, m1_we, m1_sign;
   logic [2:0]  m1_size;
   logic [11:0] m1_addr;
   logic [31:0] m1_wdata;

   logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        dm_w, dm_r, dm_sign;
   logic [2:0]  dm_size;
   logic [11:0] dm_addr;
   logic [31:0] dm_wdata, dm_rdata;

   logic        fp_m0_gnt, fp_m0_done, fp_m0_err, fp_m1_gnt, fp_m1_done, fp_m1_err;
   logic [31:0] fp_m0_rdata, fp_m1_rdata;
   logic        fp_dm_w, fp_dm_r, fp_dm_sign;
   logic [2:0]  fp_dm_size;
   logic [11:0] fp_dm_addr;
   logic [31:0] fp_dm_wdata;

   logic [31:0] mem [0:1023];
   int          n_pass;
   int          n_total;

   localparam logic [2:0] BYTE = 3'b001;
   localparam logic [2:0] HALF = 3'b010;
   localparam logic [2:0] WORD = 3'b100;

   dmem_arbiter #(.FIXED_PRIO(0)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_sign(m0_sign), .m0_size(m0_size),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_done(m0_done),
      .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_sign(m1_sign), .m1_size(m1_size),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_done(m1_done),
      .m1_err(m1_err), .m1_rdata(m1_rdata),
      .DM_W(dm_w), .DM_R(dm_r), .DM_sign(dm_sign), .DM_size(dm_size),
      .DM_addr(dm_addr), .DM_wdata(dm_wdata), .DM_rdata(dm_rdata)
   );

   dmem_arbiter #(.FIXED_PRIO(1)) dut_fp (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_sign(m0_sign), .m0_size(m0_size),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(fp_m0_gnt), .m0_done(fp_m0_done),
      .m0_err(fp_m0_err), .m0_rdata(fp_m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_sign(m1_sign), .m1_size(m1_size),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(fp_m1_gnt), .m1_done(fp_m1_done),
      .m1_err(fp_m1_err), .m1_rdata(fp_m1_rdata),
      .DM_W(fp_dm_w), .DM_R(fp_dm_r), .DM_sign(fp_dm_sign), .DM_size(fp_dm_size),
      .DM_addr(fp_dm_addr), .DM_wdata(fp_dm_wdata), .DM_rdata(32'h0000_0000)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word-wide DMEM model: combinational read, write on rising edge
   assign dm_rdata = mem[dm_addr[11:2]];
   always @(posedge clk) begin
      if (dm_w) mem[dm_addr[11:2]] <= dm_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_m0(input logic req, input logic we, input logic [2:0] size,
                         input logic [11:0] addr, input logic [31:0] wdata);
      m0_req = req; m0_we = we; m0_sign = 1'b0; m0_size = size; m0_addr = addr; m0_wdata = wdata;
   endtask

   task automatic set_m1(input logic req, input logic we, input logic [2:0] size,
                         input logic [11:0] addr, input logic [31:0] wdata);
      m1_req = req; m1_we = we; m1_sign = 1'b0; m1_size = size; m1_addr = addr; m1_wdata = wdata;
   endtask

   initial begin
      logic [1:0] exp_g;
      n_pass  = 0;
      n_total = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      rst = 1'b1;
      set_m0(1'b0, 1'b0, 3'b000, 12'h000, 32'h0);
      set_m1(1'b0, 1'b0, 3'b000, 12'h000, 32'h0);
      @(negedge clk);
      step();

      // Reset state
      chk("rst_dm_w", dm_w, 0);
      chk("rst_dm_r", dm_r, 0);
      chk("rst_done", {m1_done, m0_done}, 0);
      chk("rst_err", {m1_err, m0_err}, 0);
      chk("rst_rdata0", m0_rdata, 0);
      chk("rst_rdata1", m1_rdata, 0);
      chk("rst_dm_addr", dm_addr, 0);
      chk("rst_dm_wdata", dm_wdata, 0);
      chk("rst_dm_size", dm_size, 0);
      chk("rst_dm_sign", dm_sign, 0);
      rst = 1'b0;
      step();

      // M0 word write then read back
      set_m0(1'b1, 1'b1, WORD, 12'h010, 32'hDEADBEEF);
      #1 chk("wr_gnt", {m1_gnt, m0_gnt}, 2'b01);
      step();
      m0_req = 1'b0;
      chk("wr_dm_w", dm_w, 1);
      chk("wr_dm_r", dm_r, 0);
      chk("wr_dm_addr", dm_addr, 12'h010);
      chk("wr_dm_wdata", dm_wdata, 32'hDEADBEEF);
      chk("wr_dm_size", dm_size, WORD);
      chk("wr_acc_gnt", m0_gnt, 0);
      step();
      chk("wr_done", m0_done, 1);
      chk("wr_err", m0_err, 0);
      chk("wr_resp_dm_w", dm_w, 0);
      step();
      chk("wr_done_pulse", m0_done, 0);
      set_m0(1'b1, 1'b0, WORD, 12'h010, 32'h0);
      #1 chk("rd_gnt", m0_gnt, 1);
      step();
      m0_req = 1'b0;
      chk("rd_dm_r", dm_r, 1);
      chk("rd_dm_w", dm_w, 0);
      step();
      chk("rd_done", m0_done, 1);
      chk("rd_rdata", m0_rdata, 32'hDEADBEEF);
      chk("rd_err", m0_err, 0);
      step();

      // Simultaneous requests straight from reset
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_m0(1'b1, 1'b0, WORD, 12'h010, 32'h0);
      set_m1(1'b1, 1'b0, WORD, 12'h010, 32'h0);
      #1 chk("tie_gnt", {m1_gnt, m0_gnt}, 2'b01);
      chk("tie_fp_gnt", {fp_m1_gnt, fp_m0_gnt}, 2'b01);
      step();
      m0_req = 1'b0;
      chk("tie_acc_gnt", {m1_gnt, m0_gnt}, 2'b00);
      step();
      chk("tie_done0", m0_done, 1);
      chk("tie_rdata0", m0_rdata, 32'hDEADBEEF);
      chk("tie_gnt1", {m1_gnt, m0_gnt}, 2'b10);
      step();
      m1_req = 1'b0;
      chk("tie_dm_r1", dm_r, 1);
      chk("tie_done0_off", m0_done, 0);
      step();
      chk("tie_done1", m1_done, 1);
      chk("tie_rdata1", m1_rdata, 32'hDEADBEEF);
      step();

      // Both held for 8 accesses: strict alternation in both modes
      m0_req = 1'b1;
      m1_req = 1'b1;
      for (int k = 0; k < 16; k++) begin
         #1;
         if (k % 2 == 0) exp_g = ((k / 2) % 2 == 0) ? 2'b01 : 2'b10;
         else            exp_g = 2'b00;
         chk($sformatf("alt_rr_%0d", k), {m1_gnt, m0_gnt}, exp_g);
         chk($sformatf("alt_fp_%0d", k), {fp_m1_gnt, fp_m0_gnt}, exp_g);
         if (k == 15) begin
            m0_req = 1'b0;
            m1_req = 1'b0;
         end
         step();
      end
      chk("alt_last_done", m1_done, 1);
      chk("alt_last_gnt", {m1_gnt, m0_gnt}, 2'b00);
      step();

      // After an M0 grant, a tie goes to M1 in round-robin but to M0 in fixed mode
      m0_req = 1'b1;
      #1 chk("solo_gnt", {m1_gnt, m0_gnt}, 2'b01);
      step();
      m0_req = 1'b0;
      step();
      step();
      m0_req = 1'b1;
      m1_req = 1'b1;
      #1 chk("prio_rr_gnt", {m1_gnt, m0_gnt}, 2'b10);
      chk("prio_fp_gnt", {fp_m1_gnt, fp_m0_gnt}, 2'b01);
      step();
      m0_req = 1'b0;
      m1_req = 1'b0;
      step();
      step();

      // Misaligned half-word and bad size code
      set_m1(1'b1, 1'b0, HALF, 12'h003, 32'h0);
      #1 chk("mis_gnt", m1_gnt, 1);
      step();
      m1_req = 1'b0;
      chk("mis_dm_r", dm_r, 0);
      chk("mis_dm_w", dm_w, 0);
      step();
      chk("mis_done", m1_done, 1);
      chk("mis_err", m1_err, 1);
      chk("mis_rdata", m1_rdata, 32'hDEADBEEF);
      step();
      chk("mis_err_pulse", m1_err, 0);
      set_m1(1'b1, 1'b0, 3'b011, 12'h000, 32'h0);
      #1;
      step();
      m1_req = 1'b0;
      chk("bad_size_dm_r", dm_r, 0);
      step();
      chk("bad_size_done", m1_done, 1);
      chk("bad_size_err", m1_err, 1);
      step();

      // Reset during ACC of an M0 write aborts it
      set_m0(1'b1, 1'b1, WORD, 12'h020, 32'h12345678);
      #1 chk("abort_gnt", m0_gnt, 1);
      step();
      m0_req = 1'b0;
      chk("abort_dm_w_acc", dm_w, 1);
      rst = 1'b1;
      step();
      chk("abort_dm_w", dm_w, 0);
      chk("abort_done", m0_done, 0);
      chk("abort_dm_addr", dm_addr, 0);
      chk("abort_dm_wdata", dm_wdata, 0);
      chk("abort_dm_size", dm_size, 0);
      chk("abort_rdata1", m1_rdata, 0);
      rst = 1'b0;
      step();
      chk("abort_no_done", m0_done, 0);
      chk("abort_idle_dm_w", dm_w, 0);

      // One-cycle M1 pulse still completes; an M0 blip inside ACC is ignored
      set_m1(1'b1, 1'b0, WORD, 12'h010, 32'h0);
      #1 chk("pulse_gnt", m1_gnt, 1);
      step();
      m1_req = 1'b0;
      chk("pulse_dm_r", dm_r, 1);
      chk("pulse_dm_addr", dm_addr, 12'h010);
      set_m0(1'b1, 1'b0, WORD, 12'h010, 32'h0);
      #1 chk("blip_acc_gnt", m0_gnt, 0);
      #1 m0_req = 1'b0;
      step();
      chk("pulse_done", m1_done, 1);
      chk("pulse_rdata", m1_rdata, 32'hDEADBEEF);
      chk("pulse_err", m1_err, 0);
      chk("blip_resp_gnt", m0_gnt, 0);
      step();
      chk("blip_dm_r", dm_r, 0);
      chk("blip_done", m0_done, 0);
      step();
      chk("blip_no_access", dm_r, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0; 0 = round-robin between M0 and M1, 1 = M0 always wins ties.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports m0_req/m1_req  input  1  access request; fields held stable until done.
REQ-005 SHALL have ports mX_we  input  1  1 = write, 0 = read (X = 0, 1).
REQ-006 SHALL have ports mX_sign  input  1  sign-extend on sub-word reads.
REQ-007 SHALL have ports mX_size  input  3  access size code.
REQ-008 SHALL have ports mX_addr  input  12  byte address.
REQ-009 SHALL have ports mX_wdata  input  32  write data.
REQ-010 SHALL have ports mX_gnt  output  1  one-cycle pulse: request accepted.
REQ-011 SHALL have ports mX_done  output  1  one-cycle pulse: access complete.
REQ-012 SHALL have ports mX_err  output  1  valid with done: misaligned, no access performed.
REQ-013 SHALL have ports mX_rdata  output  32  read data, valid with done.
REQ-014 SHALL have ports DM_W, DM_R  output  1 each  DMEM write/read strobes.
REQ-015 SHALL have ports DM_sign  output  1, DM_size  output  3, DM_addr  output  12, DM_wdata  output  32  DMEM command fields.
REQ-016 SHALL have port DM_rdata  input  32  DMEM read data, combinational from DM_addr.

Function
REQ-017 SHALL implement FSM IDLE, ACC, RESP; all outputs registered or decoded from state plus latched command only.
REQ-018 In IDLE with any req high, SHALL pick a winner, latch its fields and owner id, pulse its gnt in the same cycle, and go to ACC.
REQ-019 In ACC, SHALL drive DM_R (we=0) or DM_W (we=1) from the latched command for exactly one cycle, capture DM_rdata at the end of the cycle, and go to RESP.
REQ-020 In RESP, SHALL pulse the owner's done with rdata/err valid; rdata SHALL hold until the next done to that requester.
REQ-021 In RESP, SHALL arbitrate excluding the current owner; if the other req is high, grant it and go to ACC, else go to IDLE.
REQ-022 Latency SHALL be: req seen in IDLE at cycle t -> gnt at t, DMEM strobe at t+1, done at t+2; back-to-back alternating throughput is one access per 2 cycles.
REQ-023 Round-robin SHALL favour the requester not granted last; the last-grant register updates on every gnt.
REQ-024 With FIXED_PRIO=1, M0 SHALL win whenever both requests are eligible.
REQ-025 Size codes SHALL be BYTE=3'b001, HALF=3'b010, WORD=3'b100; other codes SHALL be treated as misaligned.
REQ-026 Misaligned (WORD with addr[1:0]!=0, HALF with addr[0]!=0, or bad size) SHALL skip the DM strobes in ACC, return done with err=1, and leave rdata unchanged.
REQ-027 A req dropped before gnt SHALL cause no access; a req dropped after gnt SHALL still complete, and done SHALL still pulse.
REQ-028 DM_W and DM_R SHALL never be high together and SHALL be low outside ACC.

Reset
REQ-029 On rst high at a clock edge: state=IDLE; DM_W=DM_R=0; all gnt/done/err=0; rdata=0; DM_addr/DM_wdata/DM_size/DM_sign=0; last-grant=M1, so M0 wins the first tie.
REQ-030 rst asserted in ACC or RESP SHALL abort: no done pulse is issued, and a strobe is dropped from the next cycle.

Structure
REQ-031 Size codes, FSM state encoding and owner-id constants SHALL live in the shared package dmem_arb_pkg.
REQ-032 The two-way winner selection (req0, req1, last, exclude, fixed -> winner, valid) SHALL be one sub-module, rr_pick2.

Verification
REQ-033 M0 single WORD write addr 0x010, data 0xDEADBEEF, then read -> gnt at t, DM_W at t+1, done at t+2; read done returns 0xDEADBEEF, err=0.
REQ-034 Both req same cycle from reset (round-robin) -> M0 granted first and M1 granted in M0's RESP cycle; done order M0, M1, cycles 4 apart from the first gnt.
REQ-035 Both req held continuously for 8 accesses -> grants strictly alternate M0/M1; with FIXED_PRIO=1 grants still alternate because the owner is excluded in RESP.
REQ-036 M1 HALF read addr 0x003 -> no DM_R strobe, done with err=1, rdata unchanged; size 3'b011 at addr 0x000 -> err=1.
REQ-037 rst pulsed during ACC of an M0 write -> no done, DM_W low the next cycle, all outputs at their reset values.
REQ-038 M1 req pulses one cycle in IDLE then drops -> gnt and access still occur, and done pulses at t+2.
